// File: rtl/instr_cycle_sequencer.sv
// Instruction-cycle sequencer: walks FETCH/DECODE/EXEC/WB, pulses each unit's start, and waits for its done.
// Optional macro SEQ_SINGLE_STEP_EN adds a step input so that exactly one instruction runs per step pulse.
module instr_cycle_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned COUNT_W        = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic               halt_req,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic               step,
`endif
   input  logic               fetch_done,
   input  logic               decode_done,
   input  logic               exec_done,
   input  logic               wb_done,
   output logic               start_fetch,
   output logic               start_decode,
   output logic               start_exec,
   output logic               start_wb,
   output logic [2:0]         phase,
   output logic [COUNT_W-1:0] count,
   output logic               busy,
   output logic               timeout_err
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;
   localparam logic [2:0] S_ERROR  = 3'd6;

   // The timer value that completes the last cycle a unit is allowed to answer in.
   localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [2:0]         r_state;
   logic [7:0]         r_timer;
   logic [COUNT_W-1:0] r_count;
   logic               r_start_fetch;
   logic               r_start_decode;
   logic               r_start_exec;
   logic               r_start_wb;
   logic               r_busy;
   logic               r_timeout_err;

   logic [2:0]         w_next;
   logic [2:0]         w_after_wb;
   logic               w_go;
   logic               w_done;
   logic               w_done_valid;
   logic               w_limit;
   logic               w_retire;
   logic               w_next_busy;
   logic               w_entering;

`ifdef SEQ_SINGLE_STEP_EN
   assign w_go       = enable && step;
   assign w_after_wb = halt_req ? S_HALT : S_IDLE;
`else
   assign w_go       = enable;
   assign w_after_wb = halt_req ? S_HALT : (enable ? S_FETCH : S_IDLE);
`endif

   // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      w_done = 1'b0;
      case (r_state)
         S_FETCH:  w_done = fetch_done;
         S_DECODE: w_done = decode_done;
         S_EXEC:   w_done = exec_done;
         S_WB:     w_done = wb_done;
         default:  w_done = 1'b0;
      endcase
   end

   // A done in the start-pulse cycle (timer still zero) belongs to no request yet.
   assign w_done_valid = w_done && (r_timer != 8'd0);
   assign w_limit      = (r_timer == TIMER_LAST);
   assign w_retire     = (r_state == S_WB) && w_done_valid;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (halt_req)  w_next = S_HALT;
            else if (w_go) w_next = S_FETCH;
         end
         S_FETCH: begin
            if (w_done_valid) w_next = S_DECODE;
            else if (w_limit) w_next = S_ERROR;
         end
         S_DECODE: begin
            if (w_done_valid) w_next = S_EXEC;
            else if (w_limit) w_next = S_ERROR;
         end
         S_EXEC: begin
            if (w_done_valid) w_next = S_WB;
            else if (w_limit) w_next = S_ERROR;
         end
         S_WB: begin
            if (w_done_valid) w_next = w_after_wb;
            else if (w_limit) w_next = S_ERROR;
         end
         S_HALT:  w_next = S_HALT;
         S_ERROR: if (!enable) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   assign w_next_busy = (w_next >= S_FETCH) && (w_next <= S_WB);
   assign w_entering  = (w_next != r_state);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_timer        <= 8'd0;
         r_count        <= '0;
         r_start_fetch  <= 1'b0;
         r_start_decode <= 1'b0;
         r_start_exec   <= 1'b0;
         r_start_wb     <= 1'b0;
         r_busy         <= 1'b0;
         r_timeout_err  <= 1'b0;
      end else begin
         r_state        <= w_next;
         r_timer        <= (w_entering || !w_next_busy) ? 8'd0 : r_timer + 8'd1;
         r_start_fetch  <= w_entering && (w_next == S_FETCH);
         r_start_decode <= w_entering && (w_next == S_DECODE);
         r_start_exec   <= w_entering && (w_next == S_EXEC);
         r_start_wb     <= w_entering && (w_next == S_WB);
         r_busy         <= w_next_busy;
         r_timeout_err  <= (w_next == S_ERROR);
         if (w_retire) r_count <= r_count + COUNT_W'(1);
      end
   end

   assign start_fetch  = r_start_fetch;
   assign start_decode = r_start_decode;
   assign start_exec   = r_start_exec;
   assign start_wb     = r_start_wb;
   assign phase        = r_state;
   assign count        = r_count;
   assign busy         = r_busy;
   assign timeout_err  = r_timeout_err;

endmodule
